// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - 8-tap FIR sequencer driving an external coefficient ROM
//
// Accepts one unsigned sample per transaction (in_valid/in_ready), shifts it
// into an 8-entry delay line, walks ROM taps 0..7 and multiply-accumulates
// coefficient * delayed sample, then holds the result on out_valid/out_data
// until out_ready.
//
// Ports:
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready       sample handshake, in_data is the sample
//   clear                   zero the delay line (only while idle)
//   rom_en/rom_addr         ROM read strobe and tap address
//   rom_out                 ROM coefficient, one cycle after rom_en
//   out_valid/out_ready     result handshake, out_data is the filter output
//   busy                    transaction in progress

module fir_seq_ctrl #(
  parameter int DATA_W  = 8,
  parameter int COEFF_W = 8,
  parameter int OUT_W   = 19
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               clear,
  output logic               rom_en,
  output logic [2:0]         rom_addr,
  input  logic [COEFF_W-1:0] rom_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               busy
);

  localparam int PROD_W = DATA_W + COEFF_W;
  localparam int LINE_W = 8 * DATA_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         tap_cnt_q, tap_cnt_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  // Delay line packed as x[7]..x[0], x[0] (newest) in the low DATA_W bits.
  logic [LINE_W-1:0]  x_q, x_d;
  logic               mac_v_q, mac_v_d;
  logic [2:0]         mac_idx_q, mac_idx_d;

  logic [DATA_W-1:0]  x_sel;
  logic [PROD_W-1:0]  prod;
  logic               accept;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      tap_cnt_q <= '0;
      acc_q     <= '0;
      x_q       <= '0;
      mac_v_q   <= 1'b0;
      mac_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
      acc_q     <= acc_d;
      x_q       <= x_d;
      mac_v_q   <= mac_v_d;
      mac_idx_q <= mac_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    acc_d     = acc_q;
    x_d       = x_q;
    accept    = 1'b0;

    // The ROM output lags rom_addr by one cycle, so the MAC stage works on
    // the tap index registered alongside the read.
    mac_v_d   = (state_q == S_RUN);
    mac_idx_d = tap_cnt_q;
    x_sel     = x_q[mac_idx_q*DATA_W +: DATA_W];
    prod      = rom_out * x_sel;

    if (mac_v_q) begin
      acc_d = acc_q + {{(OUT_W-PROD_W){1'b0}}, prod};
    end

    unique case (state_q)
      S_IDLE: begin
        if (clear) begin
          x_d = '0;
        end
        if (in_valid) begin
          accept    = 1'b1;
          // Clear takes effect before the shift when both arrive together.
          x_d       = clear ? {{(LINE_W-DATA_W){1'b0}}, in_data}
                            : {x_q[LINE_W-DATA_W-1:0], in_data};
          acc_d     = '0;
          tap_cnt_d = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        tap_cnt_d = tap_cnt_q + 3'd1;
        if (tap_cnt_q == 3'd7) begin
          state_d = S_LAST;
        end
      end
      S_LAST: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    rom_en    = (state_q == S_RUN);
    rom_addr  = (state_q == S_RUN) ? tap_cnt_q : 3'd0;
    out_valid = (state_q == S_DONE);
    out_data  = (state_q == S_DONE) ? acc_q : '0;
    busy      = (state_q != S_IDLE);
  end

endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
- Sequencer for the 8-tap FIR coefficient ROM (`rom`, COEFF_W=8, 3-bit address, 1-cycle registered read, `en` gated).
- Accepts one input sample per transaction through a valid/ready handshake and shifts it into an 8-entry sample delay line.
- Walks ROM addresses 0..7, multiply-accumulates coefficient × delayed sample, and presents the filter output through a valid/ready handshake.
- Sits between the sample source and downstream logic; the ROM instance sits beside it, driven by rom_en/rom_addr and returning rom_out.

Parameters:
- DATA_W, 8, input sample width, unsigned.
- COEFF_W, 8, coefficient width; must match the ROM's coeff_width.
- OUT_W, 19, accumulator/output width = DATA_W+COEFF_W+3. No overflow is possible for 8 taps.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample offered.
- in_ready  out  1  controller can accept a sample.
- in_data  in  DATA_W  sample, unsigned.
- clear  in  1  synchronous delay-line clear; honoured only in IDLE.
- rom_en  out  1  ROM read enable.
- rom_addr  out  3  ROM tap address.
- rom_out  in  COEFF_W  ROM registered coefficient.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_data  out  OUT_W  filter result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; tap_cnt=0; acc=0; all 8 delay-line entries x[0..7]=0; mac_v=0.
  - Outputs: in_ready=1, rom_en=0, rom_addr=0, out_valid=0, out_data=0, busy=0.
  - Reset asserted mid-operation aborts the computation immediately. No result is emitted, and the delay line is lost.
- States: IDLE, RUN, LAST, DONE.
- IDLE:
  - in_ready=1.
  - On edge E0 with in_valid=1, shift the delay line: x[k]<=x[k-1] for k=1..7, x[0]<=in_data. Also acc<=0, tap_cnt<=0, go to RUN.
  - If clear=1 and in_valid=0: x[0..7]<=0, stay IDLE.
  - If clear=1 and in_valid=1 on the same edge: clear is applied first, then the shift. Result: x[0]=in_data, all others 0.
- RUN:
  - rom_en=1 and rom_addr=tap_cnt, combinational from state.
  - tap_cnt increments each edge. At tap_cnt=7, the next edge goes to LAST and tap_cnt returns to 0.
  - RUN occupies exactly 8 cycles.
- LAST:
  - rom_en=0, one cycle, drains the ROM latency.
  - Next edge goes to DONE.
- MAC pipeline:
  - mac_v<=(state==RUN); mac_idx<=tap_cnt.
  - On each edge with mac_v=1: acc<=acc+rom_out*x[mac_idx], unsigned, zero-extended to OUT_W.
  - Accumulations occur on edges E2..E9 for taps 0..7.
- DONE:
  - out_valid=1 and out_data=acc, held stable until out_ready=1.
  - The edge with out_ready=1 returns to IDLE, and out_valid drops.
  - in_ready=0 throughout DONE, so no new sample is accepted in the handover cycle.
- Latency: accept at E0 → out_valid high from E9. Minimum transaction period is 11 cycles with out_ready held high: RUN 8, LAST 1, DONE 1, IDLE 1.
- Ignored inputs:
  - in_valid while not IDLE: ignored; the sample is not consumed.
  - out_ready outside DONE: ignored.
  - clear outside IDLE: ignored.
- Result definition: y = Σ_{k=0..7} c[k]·x[k], where x[0] is the newest sample.

Test Plan:
- Impulse: ROM = 8,7,6,5,4,3,2,1. After reset, feed 1 then seven 0s with out_ready=1 → outputs 8,7,6,5,4,3,2,1, then 0 on a ninth sample of 0.
- Step: feed nine 1s → outputs 8,15,21,26,30,33,35,36,36.
- Max value: feed eight 255s → eighth output 9180 (255·36). No wrap occurs.
- Timing/backpressure:
  - Accept at E0 → out_valid rises at E9.
  - Hold out_ready=0 for 5 cycles → out_valid and out_data stay stable, in_ready=0, in_valid is ignored.
  - Release out_ready → IDLE one edge later.
- rom_en checks: asserted for exactly 8 consecutive cycles per transaction with rom_addr 0..7, and is 0 in IDLE, LAST and DONE.
- Reset mid-RUN: assert reset_n=0 at tap 4 → all outputs return to their reset values at once and the delay line reads zero. Then feed 1 → output 8.
- Clear: after a step input, pulse clear in IDLE, then feed 1 → output 8.
